// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with prefetch queue feeding the FetchToDecodeBus
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   mem_req_valid/addr    fetch request to instruction memory (word aligned)
//   mem_req_ready         memory accepts the request this cycle
//   mem_rsp_valid/data    in-order instruction word response
//   redirect_valid/pc     branch/exception redirect pulse and target
//   bus_is_busy           FetchToDecodeBus occupancy flag
//   bus_send/pc/insn      registered one-cycle write pulse and payload into the bus
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        bus_is_busy,
   output logic        bus_send,
   output logic [31:0] bus_pc,
   output logic [31:0] bus_insn
);

   localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

   state_t        state, state_next;
   logic [31:0]   pc, pc_next;
   logic [31:0]   rsp_pc, rsp_pc_next;
   logic [CW-1:0] count, count_next;
   logic [CW-1:0] outstanding, outstanding_next;
   logic [CW-1:0] discard, discard_next;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   q_addr [QUEUE_DEPTH];
   logic [31:0]   q_data [QUEUE_DEPTH];
   logic [CW:0]   inflight;
   logic          req_fire, rsp_take, push, pop;
   logic          unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   // Queued plus requested words may never exceed the queue size, so every
   // response that comes back always has a slot waiting for it.
   assign inflight      = {1'b0, count} + {1'b0, outstanding};
   assign mem_req_valid = (state == RUN) && (inflight < DEPTH_W);
   assign mem_req_addr  = pc;
   assign req_fire      = mem_req_valid && mem_req_ready;
   assign rsp_take      = mem_rsp_valid && (outstanding != '0);
   assign push          = rsp_take && (state == RUN) && !redirect_valid;
   // bus_send gating covers the cycle before bus_is_busy reflects our own write.
   assign pop           = (count != '0) && !bus_is_busy && !bus_send && !redirect_valid;

   always_comb begin
      state_next       = state;
      pc_next          = pc;
      rsp_pc_next      = rsp_pc;
      outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_take);
      discard_next     = discard;
      count_next       = count + CW'(push) - CW'(pop);

      if (req_fire) begin
         pc_next = pc + 32'd4;
      end
      // rsp_pc tracks the address of the next response that will be kept.
      if (push) begin
         rsp_pc_next = rsp_pc + 32'd4;
      end
      if ((state == DRAIN) && rsp_take) begin
         discard_next = discard - CW'(1);
      end

      if (redirect_valid) begin
         pc_next     = {redirect_pc[31:2], 2'b00};
         rsp_pc_next = {redirect_pc[31:2], 2'b00};
         count_next  = '0;
         // While draining, every outstanding word is already marked for discard.
         if (state != DRAIN) begin
            discard_next = outstanding_next;
         end
      end

      case (state)
         BOOT:    state_next = RUN;
         RUN:     if (redirect_valid && (discard_next != '0)) state_next = DRAIN;
         DRAIN:   if (discard_next == '0) state_next = RUN;
         default: state_next = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         bus_send    <= 1'b0;
         bus_pc      <= '0;
         bus_insn    <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         rsp_pc      <= rsp_pc_next;
         count       <= count_next;
         outstanding <= outstanding_next;
         discard     <= discard_next;
         bus_send    <= pop;
         if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         if (pop) begin
            bus_pc   <= q_addr[rd_ptr];
            bus_insn <= q_data[rd_ptr];
         end
      end
   end

   // Queue storage needs no reset; occupancy is tracked by count and pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= rsp_pc;
         q_data[wr_ptr] <= mem_rsp_data;
      end
   end

   rsp_without_request: assert property (@(posedge clk) disable iff (!reset_n)
      !(mem_rsp_valid && (outstanding == '0)));

endmodule
